// File: rtl/display_arbiter.sv
// display_arbiter
// Shares one 4-digit seven-segment display between four requesters using
// round-robin arbitration with a minimum dwell time per owner.
//
// Ports:
//   clk          system clock, all state updates on rising edge
//   reset        asynchronous, active-high reset
//   req[3:0]     request per requester (bit i = requester i)
//   data_in[63:0] requester values, slice i = data_in[16*i +: 16]
//   lock         suppresses dwell-expiry handover while high
//   display_data registered value for the display multiplexer
//   grant[3:0]   registered one-hot owner, 0 when idle
//   owner[1:0]   registered owner index, holds last value when idle
//   valid        registered, 1 when grant is non-zero
module display_arbiter #(
    parameter int          DWELL_CYCLES = 50000000,
    parameter int          DWELL_BITS   = 26,
    parameter logic [15:0] IDLE_VALUE   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [63:0] data_in,
    input  logic        lock,
    output logic [15:0] display_data,
    output logic [3:0]  grant,
    output logic [1:0]  owner,
    output logic        valid
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [DWELL_BITS-1:0] DWELL_LOAD = DWELL_BITS'(DWELL_CYCLES - 1);
    localparam logic [DWELL_BITS-1:0] CNT_ZERO   = {DWELL_BITS{1'b0}};
    localparam logic [DWELL_BITS-1:0] CNT_ONE    = DWELL_BITS'(1);

    // Round-robin search starting after 'last'; the entry at 'last' itself
    // is tried last. Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] last);
        logic       found;
        logic [1:0] idx;
        logic [1:0] win;
        found = 1'b0;
        win   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    state_t                state_r, state_s;
    logic [3:0]            grant_r, grant_s;
    logic [1:0]            owner_r, owner_s;
    logic                  valid_r, valid_s;
    logic [15:0]           data_r, data_s;
    logic [DWELL_BITS-1:0] cnt_r, cnt_s;
    logic [1:0]            last_r, last_s;

    logic [2:0]            pick_all_s;
    logic [2:0]            pick_other_s;
    logic [15:0]           own_slice_s;
    logic [15:0]           win_slice_s;
    logic                  take_s;
    logic [1:0]            win_s;

    // Candidate winners: from all requesters (idle) and excluding the owner (hold).
    assign pick_all_s   = rr_pick(req, last_r);
    assign pick_other_s = rr_pick(req & ~(4'b0001 << owner_r), last_r);
    assign own_slice_s  = data_in[{owner_r, 4'b0000} +: 16];
    assign win_slice_s  = data_in[{win_s, 4'b0000} +: 16];

    // Next-state and next-output decisions for the arbitration FSM.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        owner_s = owner_r;
        valid_s = valid_r;
        data_s  = data_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        take_s  = 1'b0;
        win_s   = 2'd0;

        case (state_r)
            ST_IDLE: begin
                if (pick_all_s[2]) begin
                    take_s = 1'b1;
                    win_s  = pick_all_s[1:0];
                end else begin
                    grant_s = 4'b0000;
                    valid_s = 1'b0;
                    data_s  = IDLE_VALUE;
                end
            end
            ST_HOLD: begin
                if (!req[owner_r]) begin
                    // Owner released: release wins over a simultaneous expiry.
                    if (pick_other_s[2]) begin
                        take_s = 1'b1;
                        win_s  = pick_other_s[1:0];
                    end else begin
                        state_s = ST_IDLE;
                        grant_s = 4'b0000;
                        valid_s = 1'b0;
                        data_s  = IDLE_VALUE;
                    end
                end else if ((cnt_r == CNT_ZERO) && !lock) begin
                    if (pick_other_s[2]) begin
                        take_s = 1'b1;
                        win_s  = pick_other_s[1:0];
                    end else begin
                        cnt_s  = DWELL_LOAD;
                        data_s = own_slice_s;
                    end
                end else if (cnt_r == CNT_ZERO) begin
                    // Locked at expiry: counter parks at zero until lock drops.
                    data_s = own_slice_s;
                end else begin
                    cnt_s  = cnt_r - CNT_ONE;
                    data_s = own_slice_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 4'b0000;
                valid_s = 1'b0;
                data_s  = IDLE_VALUE;
                cnt_s   = CNT_ZERO;
            end
        endcase

        if (take_s) begin
            state_s = ST_HOLD;
            grant_s = 4'b0001 << win_s;
            owner_s = win_s;
            valid_s = 1'b1;
            data_s  = win_slice_s;
            cnt_s   = DWELL_LOAD;
            last_s  = win_s;
        end else begin
            last_s = last_r;
        end
    end

    // State and output registers; pointer resets to 3 so requester 0 is searched first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            grant_r <= 4'b0000;
            owner_r <= 2'd0;
            valid_r <= 1'b0;
            data_r  <= IDLE_VALUE;
            cnt_r   <= CNT_ZERO;
            last_r  <= 2'd3;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            owner_r <= owner_s;
            valid_r <= valid_s;
            data_r  <= data_s;
            cnt_r   <= cnt_s;
            last_r  <= last_s;
        end
    end

    assign display_data = data_r;
    assign grant        = grant_r;
    assign owner        = owner_r;
    assign valid        = valid_r;

endmodule
